muldiv_unit: RTL



---
 rtl/muldiv_unit_pkg.sv | 39 +++
 rtl/muldiv_unit_div_iter.sv | 42 ++++
 rtl/muldiv_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types and op-decode helpers for the iterative RV64M multiply/divide unit.
package muldiv_unit_pkg;
  localparam int XLEN      = 64;
  localparam int MUL_STEPS = 64;
  localparam int DIV_STEPS = 64;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [3:0] {
    OP_MUL   = 4'd0,
    OP_DIV   = 4'd1,
    OP_DIVU  = 4'd2,
    OP_REM   = 4'd3,
    OP_REMU  = 4'd4,
    OP_MULW  = 4'd5,
    OP_DIVW  = 4'd6,
    OP_DIVUW = 4'd7,
    OP_REMW  = 4'd8,
    OP_REMUW = 4'd9
  } muldiv_op_t;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} muldiv_state_t;

  function automatic logic is_muldiv_w(input muldiv_op_t op);
    return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_signed_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction
endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// W forms are pre-aligned so their 32 live dividend bits shift out from the top.
module muldiv_unit_div_iter
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic            w_sel,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  word_t         rem_reg, quo_reg, dvs_reg;
  logic [XLEN:0] trial, diff;

  // The shifted partial remainder can exceed 64 bits when the divisor's MSB is set.
  always_comb begin
    trial = {rem_reg, quo_reg[XLEN-1]};
    diff  = trial - {1'b0, dvs_reg};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dvs_reg <= '0;
    end else if (start) begin
      rem_reg <= '0;
      quo_reg <= w_sel ? {dividend[31:0], 32'b0} : dividend;
      dvs_reg <= divisor;
    end else if (step) begin
      rem_reg <= diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
      quo_reg <= {quo_reg[XLEN-2:0], ~diff[XLEN]};
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: FSM, shift-add multiplier, special cases,
// sign fixup and W-form extension around the restoring divider.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [63:0] srca,
  input  logic [63:0] srcb,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);
  muldiv_state_t state_reg, state_next;
  muldiv_op_t    op_in, op_reg;
  logic [6:0]    cnt_reg, steps;
  logic          accept, w_in, sgn_in, a_neg, b_neg, special;
  logic          a_neg_reg, b_neg_reg, special_reg;
  word_t         a_eff, b_eff, a_mag, b_mag, spec_res, spec_res_reg;
  word_t         mcand_reg, mplier_reg, acc_reg, div_quo, div_rem, res;

  // Operand conditioning and special-case detection on the W-truncated operands.
  always_comb begin
    op_in  = muldiv_op_t'(op);
    w_in   = is_muldiv_w(op_in);
    sgn_in = is_signed_div(op_in);
    a_eff  = srca;
    b_eff  = srcb;
    if (w_in) begin
      a_eff = {{32{sgn_in & srca[31]}}, srca[31:0]};
      b_eff = {{32{sgn_in & srcb[31]}}, srcb[31:0]};
    end
    a_neg   = sgn_in & a_eff[XLEN-1];
    b_neg   = sgn_in & b_eff[XLEN-1];
    a_mag   = a_neg ? -a_eff : a_eff;
    b_mag   = b_neg ? -b_eff : b_eff;
    special = (b_eff == '0) ||
              (sgn_in && (b_eff == '1) &&
               (a_eff == (w_in ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)));
    if (b_eff == '0) spec_res = is_rem(op_in) ? a_eff : '1;
    else             spec_res = is_rem(op_in) ? '0 : a_eff;
    steps = 7'(is_div(op_in) ? DIV_STEPS : MUL_STEPS);
    if (w_in) steps = steps >> 1;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      S_IDLE: if (in_valid && !flush) begin
        accept = 1'b1;
        if (!is_div(op_in)) state_next = S_MUL;
        else if (special)   state_next = S_DONE;
        else                state_next = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (flush)                 state_next = S_IDLE;
        else if (cnt_reg == 7'd1)  state_next = S_DONE;
      end
      S_DONE: if (out_ready || flush) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      op_reg       <= OP_MUL;
      a_neg_reg    <= 1'b0;
      b_neg_reg    <= 1'b0;
      special_reg  <= 1'b0;
      spec_res_reg <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      acc_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cnt_reg      <= steps;
        op_reg       <= op_in;
        a_neg_reg    <= a_neg;
        b_neg_reg    <= b_neg;
        special_reg  <= special;
        spec_res_reg <= spec_res;
        mcand_reg    <= srca;
        mplier_reg   <= srcb;
        acc_reg      <= '0;
      end else if (state_reg == S_MUL || state_reg == S_DIV) begin
        cnt_reg <= cnt_reg - 7'd1;
        // Low N product bits are correct for two's complement without fixup.
        if (state_reg == S_MUL) begin
          acc_reg    <= acc_reg + (mplier_reg[0] ? mcand_reg : '0);
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
        end
      end
    end
  end

  muldiv_unit_div_iter u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && is_div(op_in)),
    .step      (state_reg == S_DIV),
    .w_sel     (w_in),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    if (!is_div(op_reg))     res = acc_reg;
    else if (special_reg)    res = spec_res_reg;
    else if (is_rem(op_reg)) res = a_neg_reg ? -div_rem : div_rem;
    else                     res = (a_neg_reg ^ b_neg_reg) ? -div_quo : div_quo;
    if (is_muldiv_w(op_reg)) res = {{32{res[31]}}, res[31:0]};
    out_data = (state_reg == S_DONE) ? res : '0;
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE);
  assign out_valid = (state_reg == S_DONE);
endmodule
